// File: rtl/layer_act_feeder.sv
// layer_act_feeder: assembles a byte stream into an N_IN-wide activation vector,
// applies it to the layer's node inputs under layer-controller metering, and
// produces a node-output valid pulse aligned to the node output register.
// Optional build macro: FEEDER_ACT_CLAMP_EN clamps each stored activation to 0..127.
module layer_act_feeder #(
  parameter int unsigned N_IN    = 10,
  parameter int unsigned DW      = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DW-1:0]      s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic               issue_en,
  output logic [N_IN*DW-1:0] a_vec,
  output logic               a_strobe,
  output logic               node_valid,
  output logic               err_short,
  output logic [15:0]        vec_count
);

  localparam int unsigned VW    = N_IN * DW;
  localparam int unsigned IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned CNT_W = $clog2(N_IN + 1);
  localparam int unsigned VC_W  = 16;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               close;
  logic               issue;

  logic [DW-1:0]      store_byte;
  logic [VW-1:0]      shadow_q;
  logic [VW-1:0]      issue_vec;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   fill_cnt_q;

  logic               s_ready_q;
  logic [VW-1:0]      a_vec_q;
  logic               a_strobe_q;
  logic [LATENCY-1:0] dly_q;
  logic               err_short_q;
  logic [VC_W-1:0]    vec_count_q;

  // Activation conditioning applied to each accepted byte before storage
  always_comb begin
`ifdef FEEDER_ACT_CLAMP_EN
    store_byte = s_data[DW-1] ? '0 : s_data;
`else
    store_byte = s_data;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake decode: close a vector on the last slot or an early s_last
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    close   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_FILL: begin
        accept = s_valid && s_ready_q;
        if (accept && (s_last || (idx_q == IDX_W'(N_IN - 1)))) begin
          close   = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (issue_en) begin
          issue   = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Shadow buffer fill; fill count is latched when the vector closes
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '0;
      idx_q      <= '0;
      fill_cnt_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < int'(N_IN); k++) begin
        if (idx_q == IDX_W'(k)) begin
          shadow_q[k*DW +: DW] <= store_byte;
        end
      end
      if (close) begin
        idx_q      <= '0;
        fill_cnt_q <= CNT_W'(idx_q) + CNT_W'(1);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // Zero-pad slots beyond the fill count so stale bytes never reach the nodes
  always_comb begin
    issue_vec = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      if (CNT_W'(k) < fill_cnt_q) begin
        issue_vec[k*DW +: DW] = shadow_q[k*DW +: DW];
      end
    end
  end

  // Ready is low only while a closed vector waits for issue
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready_q <= 1'b0;
    end else begin
      s_ready_q <= (state_d == ST_FILL);
    end
  end

  // Vector issue: apply to node inputs, strobe, count, flag short vectors
  always_ff @(posedge clk) begin
    if (reset) begin
      a_vec_q     <= '0;
      a_strobe_q  <= 1'b0;
      vec_count_q <= '0;
      err_short_q <= 1'b0;
    end else begin
      a_strobe_q <= issue;
      if (issue) begin
        a_vec_q     <= issue_vec;
        vec_count_q <= vec_count_q + VC_W'(1);
        if (fill_cnt_q != CNT_W'(N_IN)) begin
          err_short_q <= 1'b1;
        end
      end
    end
  end

  // Delay line tracking the node pipeline: capture, accumulate, activate
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q <= '0;
    end else begin
      dly_q <= LATENCY'({dly_q, a_strobe_q});
    end
  end

  assign s_ready    = s_ready_q;
  assign a_vec      = a_vec_q;
  assign a_strobe   = a_strobe_q;
  assign node_valid = dly_q[LATENCY-1];
  assign err_short  = err_short_q;
  assign vec_count  = vec_count_q;

endmodule

// File: doc/layer_act_feeder.md
Name: layer_act_feeder

Overview:
- Producer side of the per-node activation interface of a fully connected layer.
- Accepts 8-bit activations one per cycle over a valid/ready stream and assembles them into an N_IN-wide parallel vector.
- Applies the vector to all node inputs of the layer together and generates a valid flag aligned to the node output register.
- Also meters issue against a layer-controller enable and counts issued vectors.

Parameters:
- N_IN, 10, activations per vector (node input count).
- DW, 8, activation width in bits.
- LATENCY, 3, cycles from vector applied to node output valid: input capture, accumulate, activate/saturate.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_data  in  DW  activation byte, two's complement.
- s_valid  in  1  s_data valid.
- s_ready  out  1  feeder can accept s_data.
- s_last  in  1  final byte of vector; may arrive early.
- issue_en  in  1  layer controller permits a new vector to be applied.
- a_vec  out  N_IN*DW  parallel vector; slot k at bits [k*DW+DW-1 : k*DW]; slot 0 is the first byte received.
- a_strobe  out  1  one-cycle pulse when a_vec changes.
- node_valid  out  1  pulse LATENCY cycles after a_strobe.
- err_short  out  1  sticky; a vector was closed early by s_last.
- vec_count  out  16  number of vectors issued; wraps from 0xFFFF to 0.

Behaviour:
- Reset values: all outputs 0, including s_ready, a_vec, a_strobe, node_valid, err_short and vec_count.
  - Shadow buffer, fill index, pending flag and delay line are cleared.
  - s_ready rises the first cycle after reset deasserts.
  - Reset during a fill discards the partial vector. No strobe is produced for it.
- Accept rule: a byte is taken when s_valid && s_ready. It is written to shadow[idx] and idx increments.
- States:
  - FILL: accept bytes.
    - Transition to PEND on acceptance of the byte with idx==N_IN-1, or of any byte with s_last=1. Record fill count = idx+1.
    - s_last on idx==N_IN-1 is the normal case. A missing s_last at idx==N_IN-1 is also legal: the vector closes and the next byte starts a new vector.
  - PEND: s_ready=0; wait for issue_en.
    - In the cycle issue_en=1, copy shadow to a_vec. Slots with index >= fill count are driven 0 (zero pad).
    - In the same cycle: pulse a_strobe next cycle, increment vec_count, set idx=0, return to FILL.
    - If fill count < N_IN, set err_short; it stays set until reset.
- Fast path: if the closing byte is accepted while issue_en=1, the issue happens the next cycle.
  - Zero-bubble streaming: s_ready is low for exactly one cycle per vector.
- a_vec holds its value between strobes. Node inputs are therefore stable for at least LATENCY cycles whenever vectors are spaced by LATENCY or more.
- node_valid: LATENCY-deep shift register of a_strobe. Back-to-back strobes give back-to-back node_valid.
- s_data with s_valid=0 is ignored. s_last with s_valid=0 is ignored.
- No byte is lost or duplicated under any s_valid/issue_en pattern.

Optional Feature:
- Macro: FEEDER_ACT_CLAMP_EN.
- Defined: each accepted byte is clamped to the node's activation range 0..127 before storage. Negative values (bit 7 set) are stored as 0x00; 0..127 pass unchanged.
- Undefined: bytes are stored unmodified; signed values pass through.

Test Plan:
- Stream 0x01..0x0A with s_last on the 10th byte, issue_en=1:
  - a_strobe pulses once and a_vec = {0x0A,...,0x01}.
  - vec_count = 1.
  - node_valid pulses 3 cycles after a_strobe.
- Three vectors back-to-back with s_valid held high:
  - s_ready low exactly one cycle per vector; 3 strobes; vec_count = 3.
  - a_vec slot 0 holds 0x01, 0x0B, 0x15 at successive strobes.
- 4 bytes 0x11,0x22,0x33,0x44 with s_last on 0x44:
  - a_vec slots 0..3 = 0x11..0x44 and slots 4..9 = 0.
  - err_short = 1 and stays 1 across later full vectors.
- issue_en=0 while a vector completes:
  - s_ready stays 0 and no strobe.
  - Raise issue_en after 7 cycles → strobe on the next cycle, with a_vec correct.
- Reset asserted after the 5th byte of a vector:
  - All outputs 0 and no strobe.
  - The next full vector 0xA0..0xA9 is issued intact.
- FEEDER_ACT_CLAMP_EN defined, input bytes 0x80, 0xFF, 0x7F, 0x05:
  - Stored slots are 0x00, 0x00, 0x7F, 0x05.
  - With the macro undefined, the same bytes pass through unchanged.
